// File: rtl/tdc_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tdc_counter : counter-based TDC, signed saturated ref/fb phase-error code
// Revision    : 1.0 initial release
// ---------------------------------------------------------------------------
module tdc_counter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sat
);

  localparam logic [WIDTH-2:0] C_MAX_MAG = '1;
  localparam int               C_ARM     = SYNC_STAGES + 1;
  localparam int               C_ARM_W   = $clog2(C_ARM + 1);
  localparam logic [C_ARM_W-1:0] C_ARM_DONE = C_ARM_W'(C_ARM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CNT_UP = 2'd1,
    CNT_DN = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_ref_sync;
  logic [SYNC_STAGES-1:0] r_fb_sync;
  logic                   r_ref_prev;
  logic                   r_fb_prev;
  logic [C_ARM_W-1:0]     r_arm;

  logic w_armed;
  logic w_ref_rise;
  logic w_fb_rise;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-2:0] r_cnt;
  logic [WIDTH-2:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic             r_sat;
  logic             w_sat_nxt;
  logic             r_valid;
  logic             w_valid_nxt;

  logic [WIDTH-1:0] w_pos_cnt;
  logic [WIDTH-1:0] w_neg_cnt;
  logic [WIDTH-1:0] w_pos_max;
  logic [WIDTH-1:0] w_neg_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_sync <= '0;
      r_fb_sync  <= '0;
      r_ref_prev <= 1'b0;
      r_fb_prev  <= 1'b0;
      r_arm      <= '0;
    end else begin
      r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], ref_in};
      r_fb_sync  <= {r_fb_sync[SYNC_STAGES-2:0], fb_in};
      r_ref_prev <= r_ref_sync[SYNC_STAGES-1];
      r_fb_prev  <= r_fb_sync[SYNC_STAGES-1];
      if (r_arm != C_ARM_DONE) begin
        r_arm <= r_arm + 1'b1;
      end
    end
  end

  // Until the chains have flushed their reset zeros, a high input would look
  // like an edge; the arm counter masks that window.
  assign w_armed    = (r_arm == C_ARM_DONE);
  assign w_ref_rise = w_armed & r_ref_sync[SYNC_STAGES-1] & ~r_ref_prev;
  assign w_fb_rise  = w_armed & r_fb_sync[SYNC_STAGES-1] & ~r_fb_prev;

  assign w_pos_cnt = {1'b0, r_cnt};
  assign w_neg_cnt = '0 - w_pos_cnt;
  assign w_pos_max = {1'b0, C_MAX_MAG};
  assign w_neg_max = '0 - w_pos_max;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_sat_nxt   = r_sat;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_out_nxt   = '0;
          w_sat_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
        end else if (w_ref_rise) begin
          w_cnt_nxt   = (WIDTH-1)'(1);
          w_state_nxt = CNT_UP;
        end else if (w_fb_rise) begin
          w_cnt_nxt   = (WIDTH-1)'(1);
          w_state_nxt = CNT_DN;
        end
      end
      CNT_UP: begin
        if (w_fb_rise) begin
          w_out_nxt   = w_pos_cnt;
          w_sat_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == C_MAX_MAG) begin
          w_out_nxt   = w_pos_max;
          w_sat_nxt   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      CNT_DN: begin
        if (w_ref_rise) begin
          w_out_nxt   = w_neg_cnt;
          w_sat_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == C_MAX_MAG) begin
          w_out_nxt   = w_neg_max;
          w_sat_nxt   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_sat   <= w_sat_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign out       = r_out;
  assign sat       = r_sat;
  assign out_valid = r_valid;

endmodule
`default_nettype wire
